// File: rtl/ttm4_pkg.sv
// ttm4_pkg: opcodes, ALU X-source encodings, FSM state codes and decode vectors for the TTM4 sequencer
package ttm4_pkg;
   localparam logic [3:0] OP_ADD_AI = 4'h0;
   localparam logic [3:0] OP_MOV_AB = 4'h1;
   localparam logic [3:0] OP_IN_A   = 4'h2;
   localparam logic [3:0] OP_MOV_AI = 4'h3;
   localparam logic [3:0] OP_MOV_BA = 4'h4;
   localparam logic [3:0] OP_ADD_BI = 4'h5;
   localparam logic [3:0] OP_IN_B   = 4'h6;
   localparam logic [3:0] OP_MOV_BI = 4'h7;
   localparam logic [3:0] OP_AND    = 4'h8;
   localparam logic [3:0] OP_OR     = 4'h9;
   localparam logic [3:0] OP_XOR    = 4'hA;
   localparam logic [3:0] OP_OUT_B  = 4'hB;
   localparam logic [3:0] OP_ADD_AB = 4'hC;
   localparam logic [3:0] OP_OUT_I  = 4'hD;
   localparam logic [3:0] OP_JNC    = 4'hE;
   localparam logic [3:0] OP_JMP    = 4'hF;
   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_IN   = 2'b10;
   localparam logic [1:0] SEL_ZERO = 2'b11;
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_WB     = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;
   // enable vector {fa, and, or, xor}, active-high internally
   localparam logic [3:0] EN_NONE = 4'b0000;
   localparam logic [3:0] EN_FA   = 4'b1000;
   localparam logic [3:0] EN_AND  = 4'b0100;
   localparam logic [3:0] EN_OR   = 4'b0010;
   localparam logic [3:0] EN_XOR  = 4'b0001;
   // destination vector {a, b, out}, active-high internally
   localparam logic [2:0] DST_NONE = 3'b000;
   localparam logic [2:0] DST_A    = 3'b100;
   localparam logic [2:0] DST_B    = 3'b010;
   localparam logic [2:0] DST_OUT  = 3'b001;
endpackage

// File: rtl/ttm4_decode.sv
// ttm4_decode: combinational map from an instruction byte to ALU controls, destination and jump kind
module ttm4_decode
   import ttm4_pkg::*;
(
   input  logic [7:0] ir_i,
   output logic [1:0] sel_o,
   output logic [3:0] imm_o,
   output logic [3:0] en_o,
   output logic [2:0] dst_o,
   output logic       is_jump_o,
   output logic       is_jnc_o
);
   // most opcodes are FA into A from the A path with a zero immediate; each arm overrides what differs
   always_comb begin
      sel_o     = SEL_A;
      imm_o     = '0;
      en_o      = EN_FA;
      dst_o     = DST_A;
      is_jump_o = 1'b0;
      is_jnc_o  = 1'b0;
      case (ir_i[7:4])
         OP_ADD_AI: imm_o = ir_i[3:0];
         OP_MOV_AB: sel_o = SEL_B;
         OP_IN_A:   sel_o = SEL_IN;
         OP_MOV_AI: begin sel_o = SEL_ZERO; imm_o = ir_i[3:0]; end
         OP_MOV_BA: dst_o = DST_B;
         OP_ADD_BI: begin sel_o = SEL_B; imm_o = ir_i[3:0]; dst_o = DST_B; end
         OP_IN_B:   begin sel_o = SEL_IN; dst_o = DST_B; end
         OP_MOV_BI: begin sel_o = SEL_ZERO; imm_o = ir_i[3:0]; dst_o = DST_B; end
         OP_AND:    en_o = EN_AND;
         OP_OR:     en_o = EN_OR;
         OP_XOR:    en_o = EN_XOR;
         OP_OUT_B:  begin sel_o = SEL_B; dst_o = DST_OUT; end
         OP_ADD_AB: dst_o = DST_A;
         OP_OUT_I:  begin sel_o = SEL_ZERO; imm_o = ir_i[3:0]; dst_o = DST_OUT; end
         OP_JNC:    begin imm_o = ir_i[3:0]; en_o = EN_NONE; dst_o = DST_NONE; is_jnc_o = 1'b1; end
         OP_JMP:    begin imm_o = ir_i[3:0]; en_o = EN_NONE; dst_o = DST_NONE; is_jump_o = 1'b1; end
      endcase
   end
endmodule

// File: rtl/ttm4_seq_ctrl.sv
// ttm4_seq_ctrl: fetch/decode/exec/writeback sequencer for the TTM4 CPU; TTM4_SINGLE_STEP_EN adds STEP/BUSY
module ttm4_seq_ctrl
   import ttm4_pkg::*;
#(
   parameter int PC_W    = 4,
   parameter int CYC_DIV = 0
) (
   input  logic            CLK,
   input  logic            RST,
`ifdef TTM4_SINGLE_STEP_EN
   input  logic            STEP,
   output logic            BUSY,
`endif
   input  logic [7:0]      INSTR,
   input  logic            Z_FLAG,
   input  logic            C_FLAG,
   output logic [PC_W-1:0] ROM_ADDR,
   output logic [1:0]      SEL,
   output logic [3:0]      IMM,
   output logic            nFA_EN,
   output logic            nAND_EN,
   output logic            nOR_EN,
   output logic            nXOR_EN,
   output logic            nLD_A,
   output logic            nLD_B,
   output logic            nLD_OUT,
   output logic            HALTED
);
   localparam int CW = $clog2(CYC_DIV + 2);
   logic [2:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      ir_q, ir_d;
   logic [1:0]      sel_q, sel_d;
   logic [3:0]      imm_q, imm_d;
   logic [3:0]      en_q, en_d;
   logic [2:0]      ld_q, ld_d;
   logic            halted_q, halted_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            go, fetch;
   logic [1:0]      d_sel;
   logic [3:0]      d_imm, d_en;
   logic [2:0]      d_dst;
   logic            d_jump, d_jnc;
   logic [PC_W-1:0] tgt;
   logic            unused_ok;
`ifdef TTM4_SINGLE_STEP_EN
   assign go   = STEP;
   assign BUSY = state_q == S_DECODE || state_q == S_EXEC || state_q == S_WB;
`else
   assign go = 1'b1;
`endif
   // Z is carried to the controller for future conditional opcodes; no current opcode tests it
   assign unused_ok = Z_FLAG;
   assign fetch     = state_q == S_FETCH && go;
   // decoding the incoming byte during fetch lets SEL/IMM/enables be registered on the fetch edge
   assign ir_d      = fetch ? INSTR : ir_q;
   assign tgt       = PC_W'(d_imm);
   ttm4_decode u_dec (
      .ir_i      (ir_d),
      .sel_o     (d_sel),
      .imm_o     (d_imm),
      .en_o      (d_en),
      .dst_o     (d_dst),
      .is_jump_o (d_jump),
      .is_jnc_o  (d_jnc)
   );
   // next-state: controls valid DECODE..WB, load strobe only on the first WB cycle, PC moves on leaving WB
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      sel_d    = sel_q;
      imm_d    = imm_q;
      en_d     = en_q;
      ld_d     = DST_NONE;
      halted_d = halted_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_FETCH: if (go) begin
            state_d = S_DECODE;
            sel_d   = d_sel;
            imm_d   = d_imm;
            en_d    = d_en;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            state_d = S_WB;
            ld_d    = d_dst;
            cnt_d   = '0;
         end
         S_WB: if (cnt_q == CW'(CYC_DIV)) begin
            sel_d = SEL_A;
            imm_d = '0;
            en_d  = EN_NONE;
            if (d_jump && tgt == pc_q) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else begin
               state_d = S_FETCH;
               pc_d    = (d_jump || (d_jnc && !C_FLAG)) ? tgt : pc_q + 1'b1;
            end
         end else cnt_d = cnt_q + 1'b1;
         default: state_d = S_HALT;
      endcase
   end
   // state registers with asynchronous active-low reset so a reset never leaves a strobe half-issued
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         sel_q    <= SEL_A;
         imm_q    <= '0;
         en_q     <= EN_NONE;
         ld_q     <= DST_NONE;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         sel_q    <= sel_d;
         imm_q    <= imm_d;
         en_q     <= en_d;
         ld_q     <= ld_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end
   assign ROM_ADDR                          = pc_q;
   assign SEL                               = sel_q;
   assign IMM                               = imm_q;
   assign {nFA_EN, nAND_EN, nOR_EN, nXOR_EN} = ~en_q;
   assign {nLD_A, nLD_B, nLD_OUT}           = ~ld_q;
   assign HALTED                            = halted_q;
endmodule

// File: tb/tb_ttm4_seq_ctrl.sv
// tb_ttm4_seq_ctrl: table vectors, hand sequences and random programs against a per-instruction model
module tb_ttm4_seq_ctrl;
   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] INSTR;
   logic       Z_FLAG, C_FLAG;
   logic [3:0] ROM_ADDR;
   logic [1:0] SEL;
   logic [3:0] IMM;
   logic       nFA_EN, nAND_EN, nOR_EN, nXOR_EN, nLD_A, nLD_B, nLD_OUT, HALTED;
   logic [3:0] en_n;
   logic [2:0] ld_n;
   logic [7:0] rom [16];
   int         tests = 0;
   int         fails = 0;
`ifdef TTM4_SINGLE_STEP_EN
   logic       step = 1'b1;
   logic       busy;
`endif
   typedef struct {
      logic [7:0] instr;
      logic       c;
      logic       chk_si;
      logic [1:0] sel;
      logic [3:0] imm;
      logic [3:0] en;
      logic [2:0] ld;
      logic [3:0] nxt;
   } vec_t;
   vec_t vt [16];
   ttm4_seq_ctrl dut (
      .CLK      (CLK),
      .RST      (RST),
`ifdef TTM4_SINGLE_STEP_EN
      .STEP     (step),
      .BUSY     (busy),
`endif
      .INSTR    (INSTR),
      .Z_FLAG   (Z_FLAG),
      .C_FLAG   (C_FLAG),
      .ROM_ADDR (ROM_ADDR),
      .SEL      (SEL),
      .IMM      (IMM),
      .nFA_EN   (nFA_EN),
      .nAND_EN  (nAND_EN),
      .nOR_EN   (nOR_EN),
      .nXOR_EN  (nXOR_EN),
      .nLD_A    (nLD_A),
      .nLD_B    (nLD_B),
      .nLD_OUT  (nLD_OUT),
      .HALTED   (HALTED)
   );
   assign INSTR = rom[ROM_ADDR];
   assign en_n  = {nFA_EN, nAND_EN, nOR_EN, nXOR_EN};
   assign ld_n  = {nLD_A, nLD_B, nLD_OUT};
   always #5 CLK = ~CLK;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask
   task automatic do_reset;
      RST = 1'b0;
      tick();
      RST = 1'b1;
   endtask
   // one instruction from its fetch cycle to the next fetch cycle
   task automatic run_instr(input string nm, input logic chk_si, input logic [1:0] sel,
                            input logic [3:0] imm, input logic [3:0] en, input logic [2:0] ld);
      chk({nm, " fetch"}, {en_n, ld_n}, 7'h7F);
      tick();
      if (chk_si) chk({nm, " dec sel/imm"}, {SEL, IMM}, {sel, imm});
      chk({nm, " dec en/ld"}, {en_n, ld_n}, {en, 3'b111});
      tick();
      chk({nm, " exec en/ld"}, {en_n, ld_n}, {en, 3'b111});
      tick();
      if (chk_si) chk({nm, " wb sel/imm"}, {SEL, IMM}, {sel, imm});
      chk({nm, " wb en/ld"}, {en_n, ld_n}, {en, ld});
      tick();
   endtask
   // expected controls straight from the opcode map
   task automatic model(input logic [7:0] ins, output logic s, output logic [1:0] sel,
                        output logic [3:0] imm, output logic [3:0] en, output logic [2:0] ld);
      logic [3:0] op;
      op  = ins[7:4];
      sel = op < 4'h8 ? op[1:0] : op == 4'hB ? 2'd1 : op == 4'hD ? 2'd3 : 2'd0;
      imm = (op == 4'h0 || op == 4'h3 || op == 4'h5 || op == 4'h7 || op == 4'hD) ? ins[3:0] : 4'h0;
      en  = op == 4'h8 ? 4'hB : op == 4'h9 ? 4'hD : op == 4'hA ? 4'hE : op >= 4'hE ? 4'hF : 4'h7;
      ld  = op >= 4'hE ? 3'h7 : (op == 4'hB || op == 4'hD) ? 3'h6 : (op >= 4'h4 && op < 4'h8) ? 3'h5 : 3'h3;
      s   = op < 4'hC || op == 4'hD;
   endtask
   initial begin
      logic [3:0] pc, nxt, op;
      logic [1:0] msel;
      logic [3:0] mimm, men;
      logic [2:0] mld;
      logic       ms, done;
      logic [7:0] ins;
      vt[0]  = '{8'h31, 1'b0, 1'b1, 2'd3, 4'h1, 4'h7, 3'h3, 4'd1};
      vt[1]  = '{8'h02, 1'b0, 1'b1, 2'd0, 4'h2, 4'h7, 3'h3, 4'd2};
      vt[2]  = '{8'h1A, 1'b1, 1'b1, 2'd1, 4'h0, 4'h7, 3'h3, 4'd3};
      vt[3]  = '{8'h2F, 1'b0, 1'b1, 2'd2, 4'h0, 4'h7, 3'h3, 4'd4};
      vt[4]  = '{8'h45, 1'b0, 1'b1, 2'd0, 4'h0, 4'h7, 3'h5, 4'd5};
      vt[5]  = '{8'h59, 1'b1, 1'b1, 2'd1, 4'h9, 4'h7, 3'h5, 4'd6};
      vt[6]  = '{8'h63, 1'b0, 1'b1, 2'd2, 4'h0, 4'h7, 3'h5, 4'd7};
      vt[7]  = '{8'h7C, 1'b0, 1'b1, 2'd3, 4'hC, 4'h7, 3'h5, 4'd8};
      vt[8]  = '{8'h84, 1'b0, 1'b1, 2'd0, 4'h0, 4'hB, 3'h3, 4'd9};
      vt[9]  = '{8'h95, 1'b1, 1'b1, 2'd0, 4'h0, 4'hD, 3'h3, 4'd10};
      vt[10] = '{8'hA6, 1'b0, 1'b1, 2'd0, 4'h0, 4'hE, 3'h3, 4'd11};
      vt[11] = '{8'hB7, 1'b0, 1'b1, 2'd1, 4'h0, 4'h7, 3'h6, 4'd12};
      vt[12] = '{8'hE0, 1'b1, 1'b0, 2'd0, 4'h0, 4'hF, 3'h7, 4'd13};
      vt[13] = '{8'hDA, 1'b0, 1'b1, 2'd3, 4'hA, 4'h7, 3'h6, 4'd14};
      vt[14] = '{8'hEF, 1'b0, 1'b0, 2'd0, 4'h0, 4'hF, 3'h7, 4'd15};
      vt[15] = '{8'h30, 1'b1, 1'b1, 2'd3, 4'h0, 4'h7, 3'h3, 4'd0};
      for (int i = 0; i < 16; i++) rom[i] = vt[i].instr;
      RST    = 1'b0;
      Z_FLAG = 1'b0;
      C_FLAG = 1'b0;
      @(negedge CLK);
      tick();
      chk("reset state", {ROM_ADDR, SEL, IMM, en_n, ld_n, HALTED}, {4'd0, 2'd0, 4'd0, 4'hF, 3'h7, 1'b0});
      RST = 1'b1;
      // table vectors: whole 16-word program, including JNC both ways and the 15 -> 0 wrap
      for (int i = 0; i < 16; i++) begin
         C_FLAG = vt[i].c;
         run_instr($sformatf("v%0d", i), vt[i].chk_si, vt[i].sel, vt[i].imm, vt[i].en, vt[i].ld);
         chk($sformatf("v%0d next addr", i), ROM_ADDR, vt[i].nxt);
      end
      // reset in the middle of EXEC of ADD A,2 at address 1
      run_instr("mov a1", 1'b1, 2'd3, 4'h1, 4'h7, 3'h3);
      tick();
      tick();
      chk("exec before rst", {SEL, IMM, en_n}, {2'd0, 4'h2, 4'h7});
      RST = 1'b0;
      #1;
      chk("async rst", {ROM_ADDR, SEL, IMM, en_n, ld_n, HALTED}, {4'd0, 2'd0, 4'd0, 4'hF, 3'h7, 1'b0});
      tick();
      chk("held rst", {ROM_ADDR, SEL, IMM, en_n, ld_n, HALTED}, {4'd0, 2'd0, 4'd0, 4'hF, 3'h7, 1'b0});
      RST = 1'b1;
      chk("rst release addr", ROM_ADDR, 4'd0);
      tick();
      chk("refetch addr0", {SEL, IMM, en_n}, {2'd3, 4'h1, 4'h7});
      tick();
      tick();
      tick();
      chk("after refetch addr", ROM_ADDR, 4'd1);
      // JNC taken, JMP elsewhere, then self-jump halt
      do_reset();
      rom[0] = 8'hE7;
      rom[7] = 8'hF5;
      rom[5] = 8'hF5;
      C_FLAG = 1'b0;
      run_instr("jnc7", 1'b0, 2'd0, 4'h0, 4'hF, 3'h7);
      chk("jnc taken addr", ROM_ADDR, 4'd7);
      run_instr("jmp5", 1'b0, 2'd0, 4'h0, 4'hF, 3'h7);
      chk("jmp5 addr/halted", {HALTED, ROM_ADDR}, {1'b0, 4'd5});
      run_instr("jmp self", 1'b0, 2'd0, 4'h0, 4'hF, 3'h7);
      chk("self jmp halted", {HALTED, ROM_ADDR}, {1'b1, 4'd5});
      for (int i = 0; i < 20; i++) begin
         C_FLAG = 1'($urandom);
         tick();
         chk($sformatf("halt hold %0d", i), {HALTED, ROM_ADDR, en_n, ld_n}, {1'b1, 4'd5, 4'hF, 3'h7});
      end
      // random programs against the per-instruction model
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
         do_reset();
         pc   = 4'd0;
         done = 1'b0;
         for (int n = 0; n < 30 && !done; n++) begin
            ins    = rom[pc];
            op     = ins[7:4];
            C_FLAG = 1'($urandom);
            model(ins, ms, msel, mimm, men, mld);
            chk($sformatf("r%0d.%0d addr", r, n), ROM_ADDR, pc);
            run_instr($sformatf("r%0d.%0d op%0h", r, n, op), ms, msel, mimm, men, mld);
            nxt = (op == 4'hF || (op == 4'hE && !C_FLAG)) ? ins[3:0] : pc + 4'd1;
            if (op == 4'hF && ins[3:0] == pc) begin
               chk($sformatf("r%0d.%0d halt", r, n), {HALTED, ROM_ADDR}, {1'b1, pc});
               done = 1'b1;
            end else chk($sformatf("r%0d.%0d not halted", r, n), HALTED, 1'b0);
            pc = nxt;
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
